// File: rtl/decode_stage.sv
// Decode stage: combinational opcode decode registered into a one-deep output bundle,
// with a RUN/DRAIN/HALTED controller that stops fetch after a halting instruction.
module decode_stage #(
   parameter int PC_W            = 32,
   parameter int CNT_W           = 8,
   parameter int HALT_ON_ILLEGAL = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [PC_W-1:0]  in_pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [PC_W-1:0]  out_pc,
   output logic             memtoreg,
   output logic             memwrite,
   output logic             branch,
   output logic             regwrite,
   output logic             jump,
   output logic             jumpsrc,
   output logic             alusrc_a_zero,
   output logic             hlt,
   output logic [2:0]       memsize,
   output logic [1:0]       alusrcA,
   output logic [1:0]       alusrcB,
   output logic             illegal,
   output logic             halted,
   output logic [CNT_W-1:0] illegal_cnt,
   output logic [1:0]       dbg_state
);

   // Handshake: a transfer happens on a rising edge where in_valid && in_ready
   // (input side) or out_valid && out_ready (output side); flush overrides both.

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_ZERO   = 7'b0000000;

   localparam logic [1:0] SRC_A_REG  = 2'd0;
   localparam logic [1:0] SRC_A_PC   = 2'd1;
   localparam logic [1:0] SRC_B_REG  = 2'd0;
   localparam logic [1:0] SRC_B_IMM  = 2'd1;
   localparam logic [1:0] SRC_B_FOUR = 2'd2;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_out_valid;
   logic [31:0]      r_instr;
   logic [PC_W-1:0]  r_pc;
   logic             r_memtoreg, r_memwrite, r_branch, r_regwrite;
   logic             r_jump, r_jumpsrc, r_alusrc_a_zero, r_hlt, r_illegal;
   logic [2:0]       r_memsize;
   logic [1:0]       r_alusrcA, r_alusrcB;
   logic [CNT_W-1:0] r_illegal_cnt;

   logic [6:0]       w_opcode;
   logic             w_memtoreg, w_memwrite, w_branch, w_regwrite;
   logic             w_jump, w_jumpsrc, w_alusrc_a_zero, w_hlt, w_illegal;
   logic [2:0]       w_memsize;
   logic [1:0]       w_alusrcA, w_alusrcB;
   logic             w_in_ready;
   logic             w_transfer;

   assign w_opcode = in_instr[6:0];

   always_comb begin
      w_memtoreg      = 1'b0;
      w_memwrite      = 1'b0;
      w_branch        = 1'b0;
      w_regwrite      = 1'b0;
      w_jump          = 1'b0;
      w_jumpsrc       = 1'b0;
      w_alusrc_a_zero = 1'b0;
      w_hlt           = 1'b0;
      w_illegal       = 1'b0;
      w_memsize       = 3'b000;
      w_alusrcA       = SRC_A_REG;
      w_alusrcB       = SRC_B_REG;
      case (w_opcode)
         OP_AUIPC: begin
            w_alusrcA  = SRC_A_PC;
            w_alusrcB  = SRC_B_IMM;
            w_regwrite = 1'b1;
         end
         OP_LUI: begin
            w_alusrcB       = SRC_B_IMM;
            w_alusrc_a_zero = 1'b1;
            w_regwrite      = 1'b1;
         end
         OP_IMM: begin
            w_alusrcB  = SRC_B_IMM;
            w_regwrite = 1'b1;
         end
         OP_REG:    w_regwrite = 1'b1;
         OP_BRANCH: w_branch   = 1'b1;
         OP_JAL, OP_JALR: begin
            w_alusrcA  = SRC_A_PC;
            w_alusrcB  = SRC_B_FOUR;
            w_jump     = 1'b1;
            w_regwrite = 1'b1;
            w_jumpsrc  = (w_opcode == OP_JALR);
         end
         OP_LOAD: begin
            w_alusrcB  = SRC_B_IMM;
            w_regwrite = 1'b1;
            w_memtoreg = 1'b1;
            w_memsize  = in_instr[14:12];
         end
         OP_STORE: begin
            w_alusrcB  = SRC_B_IMM;
            w_memwrite = 1'b1;
            w_memsize  = in_instr[14:12];
         end
         OP_SYSTEM, OP_ZERO: w_hlt = 1'b1;
         default: begin
            w_illegal = 1'b1;
            w_hlt     = (HALT_ON_ILLEGAL != 0);
         end
      endcase
   end

   assign w_in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready) && !flush;
   assign w_transfer = in_valid && w_in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= ST_RUN;
         r_out_valid     <= 1'b0;
         r_instr         <= '0;
         r_pc            <= '0;
         r_memtoreg      <= 1'b0;
         r_memwrite      <= 1'b0;
         r_branch        <= 1'b0;
         r_regwrite      <= 1'b0;
         r_jump          <= 1'b0;
         r_jumpsrc       <= 1'b0;
         r_alusrc_a_zero <= 1'b0;
         r_hlt           <= 1'b0;
         r_illegal       <= 1'b0;
         r_memsize       <= 3'b000;
         r_alusrcA       <= 2'b00;
         r_alusrcB       <= 2'b00;
         r_illegal_cnt   <= '0;
      end else begin
         // Flush beats a coincident out_ready so DRAIN never reaches HALTED on a discarded bundle.
         if (flush && (r_state != ST_HALTED)) begin
            r_out_valid <= 1'b0;
            if (r_state == ST_DRAIN) r_state <= ST_RUN;
         end else if (w_transfer) begin
            r_out_valid     <= 1'b1;
            r_instr         <= in_instr;
            r_pc            <= in_pc;
            r_memtoreg      <= w_memtoreg;
            r_memwrite      <= w_memwrite;
            r_branch        <= w_branch;
            r_regwrite      <= w_regwrite;
            r_jump          <= w_jump;
            r_jumpsrc       <= w_jumpsrc;
            r_alusrc_a_zero <= w_alusrc_a_zero;
            r_hlt           <= w_hlt;
            r_illegal       <= w_illegal;
            r_memsize       <= w_memsize;
            r_alusrcA       <= w_alusrcA;
            r_alusrcB       <= w_alusrcB;
            if (w_hlt) r_state <= ST_DRAIN;
            if (w_illegal && (r_illegal_cnt != '1)) r_illegal_cnt <= r_illegal_cnt + 1'b1;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            if (r_state == ST_DRAIN) r_state <= ST_HALTED;
         end
      end
   end

   assign in_ready      = w_in_ready;
   assign out_valid     = r_out_valid;
   assign out_instr     = r_instr;
   assign out_pc        = r_pc;
   assign memtoreg      = r_memtoreg;
   assign memwrite      = r_memwrite;
   assign branch        = r_branch;
   assign regwrite      = r_regwrite;
   assign jump          = r_jump;
   assign jumpsrc       = r_jumpsrc;
   assign alusrc_a_zero = r_alusrc_a_zero;
   assign hlt           = r_hlt;
   assign illegal       = r_illegal;
   assign memsize       = r_memsize;
   assign alusrcA       = r_alusrcA;
   assign alusrcB       = r_alusrcB;
   assign halted        = (r_state == ST_HALTED);
   assign illegal_cnt   = r_illegal_cnt;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus a randomized stream checked against
// a queue-based reference of the decode rules and one-deep output buffering.
module tb_decode_stage;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        memtoreg, memwrite, branch, regwrite;
      logic        jump, jumpsrc, azero, hlt;
      logic [2:0]  memsize;
      logic [1:0]  srca, srcb;
      logic        illegal;
   } bundle_t;
   localparam int BW = $bits(bundle_t);

   localparam logic [31:0] I_ADDI  = 32'h00500093;
   localparam logic [31:0] I_LW    = 32'h0040A103;
   localparam logic [31:0] I_SW    = 32'h0020A423;
   localparam logic [31:0] I_JALR  = 32'h000100E7;
   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_LUI   = 32'h123450B7;
   localparam logic [31:0] I_ECALL = 32'h00000073;
   localparam logic [31:0] I_ILL   = 32'h0000007F;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, flush, out_ready;
   logic [31:0] in_instr, in_pc;

   logic        d1_in_ready, d1_out_valid, d1_memtoreg, d1_memwrite, d1_branch, d1_regwrite;
   logic        d1_jump, d1_jumpsrc, d1_azero, d1_hlt, d1_illegal, d1_halted;
   logic [31:0] d1_out_instr, d1_out_pc;
   logic [2:0]  d1_memsize;
   logic [1:0]  d1_srca, d1_srcb, d1_dbg_state;
   logic [7:0]  d1_cnt;

   logic        d2_in_ready, d2_out_valid, d2_memtoreg, d2_memwrite, d2_branch, d2_regwrite;
   logic        d2_jump, d2_jumpsrc, d2_azero, d2_hlt, d2_illegal, d2_halted;
   logic [31:0] d2_out_instr, d2_out_pc;
   logic [2:0]  d2_memsize;
   logic [1:0]  d2_srca, d2_srcb, d2_dbg_state;
   logic [1:0]  d2_cnt;

   logic [BW-1:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   decode_stage u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d1_in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(d1_out_valid),
      .out_ready(out_ready), .out_instr(d1_out_instr), .out_pc(d1_out_pc),
      .memtoreg(d1_memtoreg), .memwrite(d1_memwrite), .branch(d1_branch),
      .regwrite(d1_regwrite), .jump(d1_jump), .jumpsrc(d1_jumpsrc),
      .alusrc_a_zero(d1_azero), .hlt(d1_hlt), .memsize(d1_memsize),
      .alusrcA(d1_srca), .alusrcB(d1_srcb), .illegal(d1_illegal),
      .halted(d1_halted), .illegal_cnt(d1_cnt), .dbg_state(d1_dbg_state)
   );

   decode_stage #(.PC_W(32), .CNT_W(2), .HALT_ON_ILLEGAL(0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d2_in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(d2_out_valid),
      .out_ready(out_ready), .out_instr(d2_out_instr), .out_pc(d2_out_pc),
      .memtoreg(d2_memtoreg), .memwrite(d2_memwrite), .branch(d2_branch),
      .regwrite(d2_regwrite), .jump(d2_jump), .jumpsrc(d2_jumpsrc),
      .alusrc_a_zero(d2_azero), .hlt(d2_hlt), .memsize(d2_memsize),
      .alusrcA(d2_srca), .alusrcB(d2_srcb), .illegal(d2_illegal),
      .halted(d2_halted), .illegal_cnt(d2_cnt), .dbg_state(d2_dbg_state)
   );

   // Reference decode: srcA REG=0/PC=1, srcB REG=0/IMM=1/FOUR=2.
   function automatic bundle_t model_decode(logic [31:0] instr, logic [31:0] pc, bit halt_ill);
      bundle_t b;
      b = '0;
      b.instr = instr;
      b.pc    = pc;
      case (instr[6:0])
         7'b0010111: begin b.srca = 2'd1; b.srcb = 2'd1; b.regwrite = 1'b1; end
         7'b0110111: begin b.srcb = 2'd1; b.azero = 1'b1; b.regwrite = 1'b1; end
         7'b0010011: begin b.srcb = 2'd1; b.regwrite = 1'b1; end
         7'b0110011: b.regwrite = 1'b1;
         7'b1100011: b.branch = 1'b1;
         7'b1101111: begin b.srca = 2'd1; b.srcb = 2'd2; b.jump = 1'b1; b.regwrite = 1'b1; end
         7'b1100111: begin b.srca = 2'd1; b.srcb = 2'd2; b.jump = 1'b1; b.regwrite = 1'b1; b.jumpsrc = 1'b1; end
         7'b0000011: begin b.srcb = 2'd1; b.regwrite = 1'b1; b.memtoreg = 1'b1; b.memsize = instr[14:12]; end
         7'b0100011: begin b.srcb = 2'd1; b.memwrite = 1'b1; b.memsize = instr[14:12]; end
         7'b1110011, 7'b0000000: b.hlt = 1'b1;
         default: begin b.illegal = 1'b1; b.hlt = halt_ill; end
      endcase
      return b;
   endfunction

   function automatic bundle_t obs1();
      return {d1_out_instr, d1_out_pc, d1_memtoreg, d1_memwrite, d1_branch, d1_regwrite,
              d1_jump, d1_jumpsrc, d1_azero, d1_hlt, d1_memsize, d1_srca, d1_srcb, d1_illegal};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0;
      @(negedge clk);
      n_tests++; if (obs1() !== '0) begin n_fail++; $display("FAIL reset_bundle: got %h want 0", obs1()); end
      n_tests++; if (d1_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", d1_out_valid); end
      n_tests++; if (d1_halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", d1_halted); end
      n_tests++; if (d1_cnt !== 8'd0 || d2_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", d1_cnt, d2_cnt); end
      n_tests++; if (d1_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", d1_in_ready); end
      #1 rst_n = 1'b1;
      step();
   endtask

   task automatic test_stream();
      logic [31:0] seq [4];
      seq = '{I_ADDI, I_LW, I_SW, I_JALR};
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_instr = seq[i];
         in_pc    = 32'h100 + 32'(4 * i);
         @(negedge clk);
         n_tests++; if (d1_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b want 1", i, d1_in_ready); end
         if (i > 0) begin
            n_tests++;
            if (obs1() !== model_decode(seq[i-1], 32'h100 + 32'(4 * (i - 1)), 1'b1) || d1_out_valid !== 1'b1) begin
               n_fail++; $display("FAIL stream_out[%0d]: got %h v=%b want %h", i - 1, obs1(), d1_out_valid,
                                  model_decode(seq[i-1], 32'h100 + 32'(4 * (i - 1)), 1'b1));
            end
         end
         step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      n_tests++; if (obs1() !== model_decode(I_JALR, 32'h10C, 1'b1)) begin n_fail++; $display("FAIL stream_jalr: got %h", obs1()); end
      n_tests++; if (d1_jump !== 1'b1 || d1_jumpsrc !== 1'b1 || d1_srcb !== 2'd2) begin
         n_fail++; $display("FAIL stream_jalr_ctl: got jump=%b jumpsrc=%b srcB=%0d want 1 1 2", d1_jump, d1_jumpsrc, d1_srcb); end
      step();
      @(negedge clk);
      n_tests++; if (d1_out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_empty: got %b want 0", d1_out_valid); end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ADD; in_pc = 32'h200;
      @(negedge clk);
      n_tests++; if (d1_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready0: got %b want 1", d1_in_ready); end
      step();
      in_instr = I_LUI; in_pc = 32'h204;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_tests++; if (d1_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready[%0d]: got %b want 0", i, d1_in_ready); end
         n_tests++; if (obs1() !== model_decode(I_ADD, 32'h200, 1'b1) || d1_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_hold[%0d]: got %h v=%b", i, obs1(), d1_out_valid); end
         step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_tests++; if (d1_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", d1_in_ready); end
      step();
      in_valid = 1'b0;
      @(negedge clk);
      n_tests++; if (obs1() !== model_decode(I_LUI, 32'h204, 1'b1) || d1_out_valid !== 1'b1) begin
         n_fail++; $display("FAIL bp_second: got %h v=%b", obs1(), d1_out_valid); end
      step();
      @(negedge clk);
      n_tests++; if (d1_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %b want 0", d1_out_valid); end
   endtask

   task automatic test_ecall_drain();
      do_reset();
      out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ECALL; in_pc = 32'h300;
      step();
      in_instr = I_ADDI; in_pc = 32'h304;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_tests++; if (d1_in_ready !== 1'b0 || d1_halted !== 1'b0) begin
            n_fail++; $display("FAIL drain[%0d]: got ready=%b halted=%b want 0 0", i, d1_in_ready, d1_halted); end
         n_tests++; if (obs1() !== model_decode(I_ECALL, 32'h300, 1'b1) || d1_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL drain_hold[%0d]: got %h v=%b", i, obs1(), d1_out_valid); end
         step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_tests++; if (d1_in_ready !== 1'b0) begin n_fail++; $display("FAIL drain_exit_ready: got %b want 0", d1_in_ready); end
      step();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_tests++; if (d1_halted !== 1'b1 || d1_in_ready !== 1'b0 || d1_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL halted[%0d]: got halted=%b ready=%b v=%b want 1 0 0", i, d1_halted, d1_in_ready, d1_out_valid); end
         step();
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      n_tests++; if (d1_halted !== 1'b1 || d1_in_ready !== 1'b0) begin
         n_fail++; $display("FAIL halted_flush: got halted=%b ready=%b want 1 0", d1_halted, d1_in_ready); end
   endtask

   task automatic test_flush_drain();
      do_reset();
      out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ECALL; in_pc = 32'h400;
      step();
      in_instr = I_ADDI; in_pc = 32'h404; flush = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      n_tests++; if (d1_in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_block: got %b want 0", d1_in_ready); end
      step();
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      n_tests++; if (d1_out_valid !== 1'b0 || d1_halted !== 1'b0 || d1_in_ready !== 1'b1) begin
         n_fail++; $display("FAIL flush_run: got v=%b halted=%b ready=%b want 0 0 1", d1_out_valid, d1_halted, d1_in_ready); end
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      n_tests++; if (obs1() !== model_decode(I_ADDI, 32'h404, 1'b1) || d1_halted !== 1'b0) begin
         n_fail++; $display("FAIL flush_resume: got %h halted=%b", obs1(), d1_halted); end
   endtask

   task automatic test_illegal_count();
      int exp_cnt;
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_instr = I_ILL;
      for (int i = 1; i <= 5; i++) begin
         in_pc = 32'h500 + 32'(4 * i);
         step();
         @(negedge clk);
         exp_cnt = (i > 3) ? 3 : i;
         n_tests++; if (d2_illegal !== 1'b1 || d2_hlt !== 1'b0 || d2_regwrite !== 1'b0 || d2_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL ill_ctl[%0d]: got ill=%b hlt=%b rw=%b v=%b want 1 0 0 1", i, d2_illegal, d2_hlt, d2_regwrite, d2_out_valid); end
         n_tests++; if (d2_cnt !== 2'(exp_cnt)) begin n_fail++; $display("FAIL ill_cnt[%0d]: got %0d want %0d", i, d2_cnt, exp_cnt); end
         n_tests++; if (d1_cnt !== 8'd1) begin n_fail++; $display("FAIL ill_halt_cnt[%0d]: got %0d want 1", i, d1_cnt); end
         if (i == 1) begin
            n_tests++; if (d1_illegal !== 1'b1 || d1_hlt !== 1'b1) begin
               n_fail++; $display("FAIL ill_halting: got ill=%b hlt=%b want 1 1", d1_illegal, d1_hlt); end
         end
      end
      in_valid = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      n_tests++; if (d2_cnt !== 2'd3 || d1_halted !== 1'b1) begin
         n_fail++; $display("FAIL ill_after_flush: got cnt=%0d halted=%b want 3 1", d2_cnt, d1_halted); end
   endtask

   task automatic test_async_reset();
      do_reset();
      out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ECALL; in_pc = 32'h600;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      n_tests++; if (d1_out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre: got %b want 1", d1_out_valid); end
      #1 rst_n = 1'b0;
      #1;
      n_tests++; if (obs1() !== '0 || d1_out_valid !== 1'b0 || d1_halted !== 1'b0 || d1_cnt !== 8'd0) begin
         n_fail++; $display("FAIL ar_clear: got %h v=%b halted=%b cnt=%0d", obs1(), d1_out_valid, d1_halted, d1_cnt); end
      #1 rst_n = 1'b1;
      in_valid = 1'b1; in_instr = I_ADDI; in_pc = 32'h608;
      #1;
      n_tests++; if (d1_in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready: got %b want 1", d1_in_ready); end
      step();
      in_valid = 1'b0;
      @(negedge clk);
      n_tests++; if (obs1() !== model_decode(I_ADDI, 32'h608, 1'b1) || d1_out_valid !== 1'b1) begin
         n_fail++; $display("FAIL ar_first: got %h v=%b", obs1(), d1_out_valid); end
   endtask

   task automatic test_random();
      logic [6:0]  ops [9];
      logic [31:0] r;
      bit          exp_rdy;
      ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
      do_reset();
      exp_q.delete();
      for (int c = 0; c < 400; c++) begin
         r        = $urandom;
         r[6:0]   = ops[$urandom_range(0, 8)];
         in_instr = r;
         in_pc    = $urandom;
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         exp_rdy = (exp_q.size() == 0) || out_ready;
         n_tests++; if (d1_in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, d1_in_ready, exp_rdy); end
         n_tests++; if (d1_out_valid !== (exp_q.size() != 0)) begin
            n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, d1_out_valid, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            n_tests++; if (obs1() !== bundle_t'(exp_q[0])) begin
               n_fail++; $display("FAIL rnd_bundle[%0d]: got %h want %h", c, obs1(), exp_q[0]); end
            if (out_ready) void'(exp_q.pop_front());
         end
         if (in_valid && exp_rdy) exp_q.push_back(model_decode(in_instr, in_pc, 1'b1));
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      @(negedge clk);
      n_tests++; if (d1_out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_drain: got %b want 0", d1_out_valid); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_ecall_drain();
      test_flush_drain();
      test_illegal_count();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning PC width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, meaning illegal-instruction counter width.
REQ-003 SHALL have parameter HALT_ON_ILLEGAL, default 1, meaning 1 = illegal opcode halts, 0 = illegal opcode becomes counted bubble.
REQ-004 SHALL have ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  stage accepts instruction.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  instruction PC.
- flush  in  1  discard held and incoming instruction.
- out_valid  out  1  registered bundle valid.
- out_ready  in  1  execute accepts bundle.
- out_instr  out  32  registered instruction.
- out_pc  out  PC_W  registered PC.
- memtoreg, memwrite, branch, regwrite, jump, jumpsrc, alusrc_a_zero, hlt  out  1 each  registered control.
- memsize  out  3  registered funct3 for LOAD/STORE.
- alusrcA, alusrcB  out  2 each  registered ALU source selects (consts.v encodings).
- illegal  out  1  registered: held instruction has unknown opcode.
- halted  out  1  stage in HALTED.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions.

Function
REQ-005 SHALL decode opcode in_instr[6:0] combinationally, register the result on transfer (in_valid && in_ready); latency 1 cycle input to output.
REQ-006 SHALL decode: AUIPC -> srcA=PC, srcB=IMM, regwrite; LUI -> srcA=REG, srcB=IMM, alusrc_a_zero, regwrite; I-type -> srcA=REG, srcB=IMM, regwrite; R-type -> REG/REG, regwrite; BRANCH -> REG/REG, branch; JAL/JALR -> srcA=PC, srcB=FOUR, jump, regwrite, jumpsrc=1 only for JALR; LOAD -> REG/IMM, regwrite, memtoreg, memsize=funct3; STORE -> REG/IMM, memwrite, memsize=funct3; SYSTEM or 7'b0 -> hlt.
REQ-007 SHALL drive every control field not listed for an opcode to 0 (no X outputs).
REQ-008 Unknown opcode SHALL set illegal=1 and all other controls 0, plus hlt=1 when HALT_ON_ILLEGAL=1.
REQ-009 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready) && !flush.
REQ-010 Output register SHALL hold all fields stable while out_valid && !out_ready.
REQ-011 out_valid SHALL clear when out_valid && out_ready with no new transfer in the same cycle.
REQ-012 FSM states RUN, DRAIN, HALTED; RUN->DRAIN on transfer of a hlt=1 instruction; DRAIN->HALTED on out_valid && out_ready; HALTED is terminal until reset.
REQ-013 In DRAIN and HALTED in_ready SHALL be 0; halted=1 only in HALTED.
REQ-014 flush SHALL clear out_valid next cycle and block transfer that cycle; from DRAIN it SHALL return to RUN; in HALTED it SHALL have no effect.
REQ-015 flush coincident with out_ready SHALL win: bundle is discarded, DRAIN does not advance to HALTED; execute ignores out_valid while flush=1.
REQ-016 illegal_cnt SHALL increment by 1 per illegal-instruction transfer, saturate at 2^CNT_W-1, and not be decremented by flush.

Reset
REQ-017 rst_n low SHALL asynchronously force state=RUN, out_valid=0, all control outputs, illegal, out_instr, out_pc and illegal_cnt to 0, halted=0.
REQ-018 rst_n asserted mid-DRAIN SHALL discard the held halting instruction; after deassertion in_ready=1 on the first edge.

Verification
REQ-019 Stream ADDI, LW (funct3=010), SW, JALR with out_ready=1 -> one bundle per cycle, 1-cycle latency; LW memsize=010, memtoreg=1; JALR jump=1, jumpsrc=1, srcB=FOUR.
REQ-020 out_ready=0 three cycles with in_valid=1 -> in_ready=0 after first transfer, bundle stable, no instruction lost or duplicated.
REQ-021 ECALL (0x00000073) with out_ready=0 two cycles then 1 -> DRAIN, in_ready=0, then halted=1 and in_ready stays 0 for 10 further cycles.
REQ-022 ECALL held in DRAIN, flush=1 with out_ready=1 -> out_valid=0 next cycle, state RUN, halted=0, in_ready=1.
REQ-023 HALT_ON_ILLEGAL=0, CNT_W=2, five opcode 7'b1111111 instructions -> illegal=1, hlt=0, regwrite=0 each; illegal_cnt 1,2,3,3,3.
REQ-024 rst_n pulsed low between clock edges while out_valid=1 -> all outputs 0 immediately, before the next edge.
